// File: rtl/freq_meas_pkg.sv
// Shared types and constants for the frequency-counter measurement sequencer.
package freq_meas_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    GATE,
    SAMPLE,
    CONVERT,
    PUBLISH
  } state_e;

  localparam int          BCD_MAX        = 99;
  localparam logic [15:0] DEFAULT_PERIOD = 16'd1000;

endpackage

// File: rtl/bin2bcd_iter.sv
// Iterative subtract-by-10 binary to two-digit BCD converter.
// Loads on start_i; done_o is high in the cycle where the remainder drops below ten.
module bin2bcd_iter #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start_i,
  input  logic [W-1:0] value_i,
  output logic         done_o,
  output logic [3:0]   tens_o,
  output logic [3:0]   units_o
);

  logic [W-1:0] work_q;
  logic [3:0]   tens_q;
  logic         active_q;
  logic         ge_ten;

  assign ge_ten = (work_q >= W'(10));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      work_q   <= '0;
      tens_q   <= '0;
      active_q <= 1'b0;
    end else if (start_i) begin
      work_q   <= value_i;
      tens_q   <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      if (ge_ten) begin
        work_q <= work_q - W'(10);
        tens_q <= tens_q + 4'd1;
      end else begin
        active_q <= 1'b0;
      end
    end
  end

  // Remainder is the units digit once fewer than ten are left.
  assign done_o  = active_q & ~ge_ten;
  assign tens_o  = tens_q;
  assign units_o = work_q[3:0];

endmodule

// File: rtl/freq_meas_sequencer.sv
// Gate-window sequencer: clears and gates the external edge counter, freezes the
// count, converts it to BCD and publishes the digits with a one-cycle strobe.
module freq_meas_sequencer #(
  parameter int                   COUNT_W        = 7,
  parameter int                   PERIOD_W       = 16,
  parameter logic [PERIOD_W-1:0]  DEFAULT_PERIOD = PERIOD_W'(freq_meas_pkg::DEFAULT_PERIOD)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                period_load,
  input  logic [PERIOD_W-1:0] period_in,
  input  logic [COUNT_W-1:0]  edge_count,
  output logic                counter_clr,
  output logic                counter_en,
  output logic [3:0]          tens,
  output logic [3:0]          units,
  output logic                overflow,
  output logic                result_valid,
  output logic                busy
);
  import freq_meas_pkg::*;

  state_e               state_q, state_d;
  logic [PERIOD_W-1:0]  period_q;
  logic [PERIOD_W-1:0]  win_len_q;
  logic [PERIOD_W-1:0]  win_cnt_q;
  logic                 ovf_acc_q;
  logic [3:0]           tens_q, units_q;
  logic                 overflow_q;
  logic                 valid_q;

  logic                 win_last;
  logic                 sample_ovf;
  logic [COUNT_W-1:0]   sample_val;
  logic                 conv_done;
  logic [3:0]           conv_tens, conv_units;

  assign win_last   = (win_cnt_q == win_len_q - PERIOD_W'(1));
  assign sample_ovf = (edge_count > COUNT_W'(BCD_MAX));
  assign sample_val = sample_ovf ? COUNT_W'(BCD_MAX) : edge_count;

  bin2bcd_iter #(.W(COUNT_W)) u_bin2bcd (
    .clk     (clk),
    .reset_n (reset_n),
    .start_i (state_q == SAMPLE),
    .value_i (sample_val),
    .done_o  (conv_done),
    .tens_o  (conv_tens),
    .units_o (conv_units)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    counter_clr = 1'b0;
    counter_en  = 1'b0;
    busy        = (state_q != IDLE);
    case (state_q)
      IDLE:    if (enable) state_d = CLEAR;
      CLEAR: begin
        counter_clr = 1'b1;
        state_d     = GATE;
      end
      GATE: begin
        counter_en = 1'b1;
        if (win_last) state_d = SAMPLE;
      end
      SAMPLE:  state_d = CONVERT;
      CONVERT: if (conv_done) state_d = PUBLISH;
      PUBLISH: state_d = enable ? CLEAR : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Window length is frozen in CLEAR so a reload only affects the next window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_q   <= DEFAULT_PERIOD;
      win_len_q  <= PERIOD_W'(1);
      win_cnt_q  <= '0;
      ovf_acc_q  <= 1'b0;
      tens_q     <= '0;
      units_q    <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (period_load) begin
        period_q <= (period_in == '0) ? PERIOD_W'(1) : period_in;
      end
      case (state_q)
        CLEAR: begin
          win_len_q <= period_q;
          win_cnt_q <= '0;
        end
        GATE:    win_cnt_q <= win_cnt_q + PERIOD_W'(1);
        SAMPLE:  ovf_acc_q <= sample_ovf;
        CONVERT: begin
          if (conv_done) begin
            tens_q     <= conv_tens;
            units_q    <= conv_units;
            overflow_q <= ovf_acc_q;
            valid_q    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign tens         = tens_q;
  assign units        = units_q;
  assign overflow     = overflow_q;
  assign result_valid = valid_q;

endmodule

// File: tb/tb_freq_meas_sequencer.sv
// Self-checking bench: emulates the edge counter and checks window lengths,
// conversion results and strobe timing against an arithmetic reference model.
module tb_freq_meas_sequencer;

  logic        clk;
  logic        reset_n = 1'b0;
  logic        enable;
  logic        period_load;
  logic [15:0] period_in;
  logic [6:0]  edge_count;
  logic        counter_clr;
  logic        counter_en;
  logic [3:0]  tens;
  logic [3:0]  units;
  logic        overflow;
  logic        result_valid;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic        force_mode;
  logic [6:0]  force_val;
  logic [6:0]  cnt;
  int unsigned edge_pct;

  typedef struct {
    int due;
    int val;
  } pend_t;

  freq_meas_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .period_load  (period_load),
    .period_in    (period_in),
    .edge_count   (edge_count),
    .counter_clr  (counter_clr),
    .counter_en   (counter_en),
    .tens         (tens),
    .units        (units),
    .overflow     (overflow),
    .result_valid (result_valid),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge-counter datapath stand-in: random edges while gated, saturating at 127.
  always @(posedge clk) begin
    if (!reset_n || counter_clr) cnt <= '0;
    else if (counter_en && cnt != 7'd127 && $urandom_range(99, 0) < edge_pct) cnt <= cnt + 7'd1;
  end
  assign edge_count = force_mode ? force_val : cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: window length = period at the clear cycle; result = BCD of min(count, 99).
  initial begin : monitor
    int    cyc;
    int    period_m;
    int    en_run;
    int    win_q[$];
    pend_t pend_q[$];
    pend_t p;
    logic  prev_en, prev_clr;
    int    last_pub;
    int    meas, clamp, exp_len;
    cyc = 0; period_m = 1000; en_run = 0; prev_en = 0; prev_clr = 0; last_pub = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        win_q.delete();
        pend_q.delete();
        en_run = 0; prev_en = 0; prev_clr = 0; last_pub = 0; period_m = 1000;
      end else begin
        if (result_valid) begin
          if (pend_q.size() == 0) begin
            check("valid_unexpected", 32'(result_valid), 0);
          end else begin
            p = pend_q.pop_front();
            check("valid_time", cyc, p.due);
            check("digits", 32'({overflow, tens, units}), p.val);
          end
          last_pub = int'({overflow, tens, units});
        end else begin
          check("hold", 32'({overflow, tens, units}), last_pub);
          if (pend_q.size() > 0 && cyc > pend_q[0].due) begin
            check("valid_missing", 32'(result_valid), 1);
            void'(pend_q.pop_front());
          end
        end
        if (counter_clr) begin
          check("clr_single", 32'(prev_clr), 0);
          check("clr_no_en", 32'(counter_en), 0);
          win_q.push_back(period_m);
        end
        if (counter_en && !prev_en) check("clr_before_en", 32'(prev_clr), 1);
        if (counter_en) begin
          en_run++;
        end else if (prev_en) begin
          exp_len = (win_q.size() > 0) ? win_q.pop_front() : 0;
          check("gate_len", en_run, exp_len);
          meas  = int'(edge_count);
          clamp = (meas > 99) ? 99 : meas;
          p.due = cyc + clamp / 10 + 2;
          p.val = ((meas > 99) ? 256 : 0) + (clamp / 10) * 16 + (clamp % 10);
          pend_q.push_back(p);
          en_run = 0;
        end
        if (period_load) period_m = (period_in == 16'd0) ? 1 : int'(period_in);
        prev_en  = counter_en;
        prev_clr = counter_clr;
      end
    end
  end

  task automatic wait_valid(input int budget, output logic [8:0] got);
    int n;
    n = 0;
    while (result_valid !== 1'b1 && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    check("valid_seen", 32'(result_valid), 1);
    got = {overflow, tens, units};
    @(posedge clk); #2;
  endtask

  task automatic wait_en(input logic lvl, input int budget);
    int n;
    n = 0;
    while (counter_en !== lvl && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    check("en_level", 32'(counter_en), 32'(lvl));
  endtask

  task automatic measure_gate(output int len);
    len = 0;
    wait_en(1'b1, 100);
    while (counter_en === 1'b1 && len < 300) begin
      len++;
      @(posedge clk); #2;
    end
  endtask

  initial begin : stim
    logic [8:0] got;
    int         len;
    int         k;
    int         dir_val[4] = '{0, 99, 120, 5};
    int         dir_exp[4] = '{'h000, 'h099, 'h199, 'h005};
    enable = 1'b1; period_load = 1'b0; period_in = '0;
    force_mode = 1'b1; force_val = 7'd47; edge_pct = 50;

    repeat (3) @(negedge clk);
    check("rst_clr", 32'(counter_clr), 0);
    check("rst_en", 32'(counter_en), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_digits", 32'({overflow, tens, units}), 0);
    check("rst_valid", 32'(result_valid), 0);

    @(posedge clk); #2; reset_n = 1'b1; #1;
    check("idle_clr", 32'(counter_clr), 0);
    check("idle_busy", 32'(busy), 0);
    @(posedge clk); #2;
    check("first_clr", 32'(counter_clr), 1);
    check("first_busy", 32'(busy), 1);
    check("first_en_low", 32'(counter_en), 0);
    @(posedge clk); #2;
    check("clr_one_cycle", 32'(counter_clr), 0);
    check("gate_open", 32'(counter_en), 1);
    period_in = 16'd10; period_load = 1'b1;
    @(posedge clk); #2; period_load = 1'b0;
    wait_valid(1500, got);
    check("conv_47", 32'(got), 'h047);

    for (int j = 0; j < 4; j++) begin
      force_val = 7'(dir_val[j]);
      measure_gate(len);
      check("gate_len_10", len, 10);
      wait_valid(100, got);
      check("conv_directed", 32'(got), dir_exp[j]);
    end

    force_mode = 1'b0;
    for (int i = 0; i < 12; i++) begin
      edge_pct = $urandom_range(100, 0);
      k = $urandom_range(20, 0);
      repeat (k) begin @(posedge clk); #2; end
      period_in = (i == 3) ? 16'd0 : 16'($urandom_range(150, 1));
      period_load = 1'b1;
      @(posedge clk); #2; period_load = 1'b0;
      wait_valid(600, got);
    end

    // Load coincident with CLEAR, then reload in the middle of a 20-cycle window.
    force_mode = 1'b1; force_val = 7'd33;
    period_in = 16'd20; period_load = 1'b1;
    @(posedge clk); #2; period_load = 1'b0;
    wait_valid(600, got);
    wait_en(1'b1, 100);
    period_in = 16'd8; period_load = 1'b1; len = 0;
    while (counter_en === 1'b1 && len < 100) begin
      len++;
      @(posedge clk); #2; period_load = 1'b0;
    end
    check("reconf_cur", len, 20);
    wait_valid(100, got);
    check("conv_33", 32'(got), 'h033);
    measure_gate(len);
    check("reconf_next", len, 8);
    wait_valid(100, got);

    force_val = 7'd73;
    wait_en(1'b1, 100);
    enable = 1'b0;
    wait_valid(100, got);
    check("drop_result", 32'(got), 'h073);
    check("drop_busy", 32'(busy), 0);
    repeat (5) begin
      @(posedge clk); #2;
      check("drop_no_clr", 32'(counter_clr), 0);
    end
    check("drop_idle", 32'(busy), 0);

    force_val = 7'd60; enable = 1'b1;
    wait_en(1'b1, 100);
    wait_en(1'b0, 100);
    @(posedge clk); #2;
    check("abort_busy", 32'(busy), 1);
    reset_n = 1'b0; #1;
    check("abort_en", 32'(counter_en), 0);
    check("abort_digits", 32'({overflow, tens, units}), 0);
    check("abort_valid", 32'(result_valid), 0);
    check("abort_idle", 32'(busy), 0);
    repeat (10) begin
      @(posedge clk); #2;
      check("abort_no_valid", 32'(result_valid), 0);
    end

    reset_n = 1'b1;
    wait_en(1'b1, 50);
    @(posedge clk); #2;
    check("gate_running", 32'(counter_en), 1);
    reset_n = 1'b0; #1;
    check("async_gate_drop", 32'(counter_en), 0);
    check("async_busy", 32'(busy), 0);
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
